// File: rtl/mux16_pkg.sv
// Shared constants, state encoding and helpers for the 16-way round-robin mux scheduler.
package mux16_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Round-robin pick: first requester at or after ptr (mod 16), optionally skipping one index.
module rr_pick16
    import mux16_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             excl_en,
    input  logic [SEL_W-1:0] excl_idx,
    output logic             found,
    output logic [SEL_W-1:0] index
);

    logic [N_REQ-1:0] mask;
    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        found = 1'b0;
        index = ptr;
        cand  = '0;
        mask  = req;
        if (excl_en) begin
            mask[excl_idx] = 1'b0;
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (mask[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler for a shared external 16:1 mux with per-grant hold limit and output sampling.
module mux16_rr_sched
    import mux16_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             y,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             dout,
    output logic             dout_valid
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             dout_q;
    logic             dout_valid_q;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             take_grant;

    // While granting, the current owner is excluded; on release its req bit is already low.
    rr_pick16 u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .excl_en  (state_q == GRANT),
        .excl_idx (sel_q),
        .found    (pick_found),
        .index    (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        take_grant = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d      = '0;
                take_grant = pick_found;
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    if (pick_found) begin
                        take_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q == HOLD_LAST) begin
                    // Timeout with nobody else waiting keeps the owner and restarts its budget.
                    if (pick_found) begin
                        take_grant = 1'b1;
                    end else begin
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (take_grant) begin
            state_d = GRANT;
            sel_d   = pick_idx;
            gnt_d   = onehot(pick_idx);
            ptr_d   = pick_idx + SEL_W'(1);
            hold_d  = '0;
        end
    end

    // Sample the external mux output one cycle behind sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= (state_q == GRANT);
            if (state_q == GRANT) begin
                dout_q <= y;
            end
        end
    end

    assign sel        = sel_q;
    assign gnt        = gnt_q;
    assign busy       = (state_q == GRANT);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed-vector bench for mux16_rr_sched at HOLD_MAX of 8, 4 and 2.
module tb_mux16_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [15:0] ydata;

    logic [3:0]  sel8, sel4, sel2;
    logic [15:0] gnt8, gnt4, gnt2;
    logic        busy8, busy4, busy2;
    logic        dout8, dout4, dout2;
    logic        dv8, dv4, dv2;
    logic        y8, y4, y2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // External 16:1 mux model per instance.
    assign y8 = ydata[sel8];
    assign y4 = ydata[sel4];
    assign y2 = ydata[sel2];

    mux16_rr_sched #(.HOLD_MAX(8)) u8 (
        .clk(clk), .rst(rst), .req(req), .y(y8),
        .sel(sel8), .gnt(gnt8), .busy(busy8), .dout(dout8), .dout_valid(dv8)
    );
    mux16_rr_sched #(.HOLD_MAX(4)) u4 (
        .clk(clk), .rst(rst), .req(req), .y(y4),
        .sel(sel4), .gnt(gnt4), .busy(busy4), .dout(dout4), .dout_valid(dv4)
    );
    mux16_rr_sched #(.HOLD_MAX(2)) u2 (
        .clk(clk), .rst(rst), .req(req), .y(y2),
        .sel(sel2), .gnt(gnt2), .busy(busy2), .dout(dout2), .dout_valid(dv2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        ydata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = '0;
        ydata = '0;
        #1;
        vectors++;
        if (gnt8 !== 16'h0000) begin miscompares++; $display("FAIL reset_gnt: got %h want 0000", gnt8); end
        vectors++;
        if (sel8 !== 4'd0) begin miscompares++; $display("FAIL reset_sel: got %0d want 0", sel8); end
        vectors++;
        if (busy8 !== 1'b0 || dv8 !== 1'b0 || dout8 !== 1'b0) begin
            miscompares++; $display("FAIL reset_flags: busy=%b dv=%b dout=%b want 0 0 0", busy8, dv8, dout8);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (busy8 !== 1'b0 || gnt8 !== 16'h0000) begin
            miscompares++; $display("FAIL idle_noreq: busy=%b gnt=%h want 0 0000", busy8, gnt8);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 16'h0020;
        tick();
        vectors++;
        if (gnt8 !== 16'h0020 || sel8 !== 4'd5) begin
            miscompares++; $display("FAIL single_grant: gnt=%h sel=%0d want 0020 5", gnt8, sel8);
        end
        vectors++;
        if (busy8 !== 1'b1 || dv8 !== 1'b0) begin
            miscompares++; $display("FAIL single_first: busy=%b dv=%b want 1 0", busy8, dv8);
        end
        ydata = 16'h0020;
        tick();
        vectors++;
        if (dout8 !== 1'b1 || dv8 !== 1'b1) begin
            miscompares++; $display("FAIL single_dout1: dout=%b dv=%b want 1 1", dout8, dv8);
        end
        ydata = 16'hFFDF;
        tick();
        vectors++;
        if (dout8 !== 1'b0 || dv8 !== 1'b1) begin
            miscompares++; $display("FAIL single_dout0: dout=%b dv=%b want 0 1", dout8, dv8);
        end
        req = '0;
        tick();
        vectors++;
        if (gnt8 !== 16'h0000 || busy8 !== 1'b0 || sel8 !== 4'd5) begin
            miscompares++; $display("FAIL single_drop: gnt=%h busy=%b sel=%0d want 0000 0 5", gnt8, busy8, sel8);
        end
        vectors++;
        if (dv8 !== 1'b1) begin miscompares++; $display("FAIL single_lastdv: got %b want 1", dv8); end
        tick();
        vectors++;
        if (dv8 !== 1'b0) begin miscompares++; $display("FAIL single_dvclr: got %b want 0", dv8); end
    endtask

    task automatic test_contention();
        logic [15:0] exp;
        do_reset();
        req = 16'h8001;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = (((i / 4) % 2) == 0) ? 16'h0001 : 16'h8000;
            vectors++;
            if (gnt4 !== exp) begin
                miscompares++; $display("FAIL contention_c%0d: gnt=%h want %h", i, gnt4, exp);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h8000;
        tick();
        vectors++;
        if (gnt8 !== 16'h8000 || sel8 !== 4'd15) begin
            miscompares++; $display("FAIL wrap_g15: gnt=%h sel=%0d want 8000 15", gnt8, sel8);
        end
        req = '0;
        tick();
        req = 16'h0003;
        tick();
        vectors++;
        if (gnt8 !== 16'h0001 || sel8 !== 4'd0) begin
            miscompares++; $display("FAIL wrap_g0: gnt=%h sel=%0d want 0001 0", gnt8, sel8);
        end
        req = '0;
        tick();
        req = 16'h0003;
        tick();
        vectors++;
        if (gnt8 !== 16'h0002 || sel8 !== 4'd1) begin
            miscompares++; $display("FAIL wrap_next: gnt=%h sel=%0d want 0002 1", gnt8, sel8);
        end
        req = '0;
        tick();
    endtask

    task automatic test_lone_timeout();
        int bad;
        do_reset();
        req = 16'h0100;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (gnt2 !== 16'h0100 || sel2 !== 4'd8 || busy2 !== 1'b1) begin
                miscompares++;
                $display("FAIL lone_timeout_c%0d: gnt=%h sel=%0d busy=%b want 0100 8 1", i, gnt2, sel2, busy2);
            end
        end
        req = 16'h0101;
        tick();
        tick();
        vectors++;
        if (gnt2 !== 16'h0001) begin
            miscompares++; $display("FAIL lone_rotate: gnt=%h want 0001", gnt2);
        end
        req = '0;
        tick();
    endtask

    task automatic test_release_handoff();
        do_reset();
        req = 16'h0008;
        tick();
        vectors++;
        if (gnt8 !== 16'h0008 || sel8 !== 4'd3) begin
            miscompares++; $display("FAIL handoff_g3: gnt=%h sel=%0d want 0008 3", gnt8, sel8);
        end
        req = 16'h0048;
        tick();
        vectors++;
        if (gnt8 !== 16'h0008) begin
            miscompares++; $display("FAIL handoff_hold: gnt=%h want 0008", gnt8);
        end
        req = 16'h0040;
        tick();
        vectors++;
        if (gnt8 !== 16'h0040 || sel8 !== 4'd6 || busy8 !== 1'b1) begin
            miscompares++; $display("FAIL handoff_g6: gnt=%h sel=%0d busy=%b want 0040 6 1", gnt8, sel8, busy8);
        end
        req = '0;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 16'h0004;
        tick();
        tick();
        vectors++;
        if (gnt8 !== 16'h0004 || dv8 !== 1'b1) begin
            miscompares++; $display("FAIL areset_pre: gnt=%h dv=%b want 0004 1", gnt8, dv8);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (gnt8 !== 16'h0000 || sel8 !== 4'd0 || dv8 !== 1'b0 || busy8 !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_mid: gnt=%h sel=%0d dv=%b busy=%b want 0000 0 0 0", gnt8, sel8, dv8, busy8);
        end
        rst = 1'b0;
        req = 16'h0006;
        tick();
        vectors++;
        if (gnt8 !== 16'h0002 || sel8 !== 4'd1) begin
            miscompares++; $display("FAIL areset_after: gnt=%h sel=%0d want 0002 1", gnt8, sel8);
        end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_lone_timeout();
        test_release_handoff();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux16_rr_sched.md
MUX16_RR_SCHED -- requirements
Module: mux16_rr_sched

Interface
REQ-001 Parameter: HOLD_MAX, default 8, max consecutive grant cycles per requester while others wait; legal range 1..255.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 Port: req  input  16  request vector; bit k = requester k wants the shared 16:1 mux path.
REQ-005 Port: y  input  1  output of the external 16:1 mux, driven by sel.
REQ-006 Port: sel  output  4  registered mux select = index of current grantee.
REQ-007 Port: gnt  output  16  registered one-hot grant; all-zero when idle.
REQ-008 Port: busy  output  1  high while state = GRANT.
REQ-009 Port: dout  output  1  registered sample of y for the current grantee.
REQ-010 Port: dout_valid  output  1  high when dout holds a sample taken under a valid grant.

Function
REQ-011 States SHALL be IDLE and GRANT only; busy = (state == GRANT).
REQ-012 Round-robin pointer ptr (4 bits) SHALL equal (last granted index + 1) mod 16; wrap 15 -> 0.
REQ-013 Pick SHALL be the first k in order ptr, ptr+1, ..., ptr+15 (mod 16) with req[k]=1, optionally excluding one index.
REQ-014 IDLE: if req != 0, next edge -> GRANT, sel = pick, gnt = one-hot(pick), hold_cnt = 0, ptr = pick+1; else remain IDLE, gnt = 0.
REQ-015 GRANT, req[sel]=1, hold_cnt < HOLD_MAX-1: hold grant; hold_cnt increments.
REQ-016 GRANT, req[sel]=0 (release): if any other req, next edge grants pick directly (no idle gap); else -> IDLE, gnt = 0, sel unchanged.
REQ-017 GRANT, req[sel]=1, hold_cnt = HOLD_MAX-1 (timeout): pick excluding sel; if another requester exists, grant it next edge; else keep sel, hold_cnt = 0, no gnt gap.
REQ-018 Release takes priority over timeout when both conditions hold in the same cycle.
REQ-019 Requests arriving or dropping for non-granted indices SHALL not affect the current grant.
REQ-020 Every new grant (including forced rotation) SHALL reload hold_cnt = 0 and update ptr.
REQ-021 dout SHALL register y every cycle with state = GRANT; dout_valid = 1 the cycle after each GRANT cycle, else 0 (latency 1 cycle from sel to dout).
REQ-022 gnt SHALL never have more than one bit set; gnt[sel]=1 whenever busy=1.

Reset
REQ-023 rst asserted SHALL immediately force state = IDLE, sel = 0, gnt = 0, ptr = 0, hold_cnt = 0, dout = 0, dout_valid = 0, busy = 0, independent of clk.
REQ-024 First arbitration after rst deassertion SHALL start from ptr = 0; a grant in progress at reset is discarded, not resumed.

Structure
REQ-025 Shared package mux16_pkg SHALL hold N_REQ = 16, SEL_W = 4, CNT_W = 8, and the state encoding (IDLE = 0, GRANT = 1).
REQ-026 Pick logic SHALL be one combinational sub-module rr_pick16 (inputs req, ptr, exclude enable/index; outputs found, index).
REQ-027 The external mux_16x1 is not instantiated inside; sel/y connect at the parent level.

Verification
REQ-028 Single: HOLD_MAX=8, req=0x0020 for 3 cycles then 0 -> gnt=0x0020, sel=5 one edge after req; dout tracks y delayed 1 cycle; gnt=0 and busy=0 one edge after drop.
REQ-029 Contention: HOLD_MAX=4, req=0x8001 held -> gnt 0x0001 for 4 cycles, 0x8000 for 4 cycles, repeating, no zero-gnt cycles.
REQ-030 Wrap: grant idx 15, release, then req=0x0003 -> next grant idx 0 (ptr wrapped to 0).
REQ-031 Lone timeout: HOLD_MAX=2, req=0x0100 held 10 cycles -> gnt=0x0100 continuously, hold_cnt restarts every 2 cycles.
REQ-032 Release handoff: grant idx 3, req=0x0048 then drop bit 3 -> gnt=0x0040 on next edge, no IDLE cycle.
REQ-033 Async reset: rst pulsed mid-cycle while gnt=0x0004 -> gnt=0, sel=0, dout_valid=0 before next clk edge; after release with req=0x0006 -> grant idx 1.
